mul8_rr_sched: RTL and testbench

Round-robin scheduler that shares one combinational `mul8` 8x8 array multiplier among `NREQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands in front of the multiplier, and registers the product with the requester's ID into a single result stream. It sits between the requesting datapath units and the shared `mul8` instance, which it instantiates internally.

---
 rtl/mul8_rr_sched.sv | 133 +++++++++++++
 tb/tb_mul8_rr_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_rr_sched.sv
// Round-robin scheduler sharing one mul8 array multiplier among NREQ requesters.
// Two-stage pipeline: S1 operand register feeding mul8, S2 result register.

module mul8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [16:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                y = y + (17'(a) << i);
            end
        end
    end
endmodule

module mul8_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       res_y
);
    logic           s1_v;
    logic [7:0]     s1_a;
    logic [7:0]     s1_b;
    logic [IDW-1:0] s1_id;
    logic           s2_v;
    logic [15:0]    s2_y;
    logic [IDW-1:0] s2_id;
    logic [IDW-1:0] last;

    logic           s2_free;
    logic           s1_free;
    logic           adv;
    logic           xfer;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [7:0]     g_a;
    logic [7:0]     g_b;
    logic [16:0]    mul_y;
    logic           unused_y16;

    assign s2_free = !s2_v || res_ready;
    assign s1_free = !s1_v || s2_free;
    assign adv     = s1_v && s2_free;
    assign xfer    = |req_ready;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last) + k) % NREQ;
            cand = IDW'(idx);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_found && s1_free && !rst) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        g_a = '0;
        g_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                g_a = req_a[8*i +: 8];
                g_b = req_b[8*i +: 8];
            end
        end
    end

    mul8 u_mul8 (
        .a (s1_a),
        .b (s1_b),
        .y (mul_y)
    );

    // Top product bit can never be set for 8-bit operands.
    assign unused_y16 = mul_y[16];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            s2_v  <= 1'b0;
            s2_y  <= '0;
            s2_id <= '0;
            last  <= IDW'(NREQ - 1);
        end else begin
            if (xfer) begin
                s1_a  <= g_a;
                s1_b  <= g_b;
                s1_id <= gnt_id;
                last  <= gnt_id;
            end
            s1_v <= xfer || (s1_v && !s2_free);
            if (adv) begin
                s2_y  <= mul_y[15:0];
                s2_id <= s1_id;
            end
            s2_v <= adv || (s2_v && !res_ready);
        end
    end

    assign res_valid = s2_v;
    assign res_id    = s2_id;
    assign res_y     = s2_y;
endmodule

// File: tb/tb_mul8_rr_sched.sv
// Directed bench for mul8_rr_sched with a result scoreboard.
// Expected products and grant order are computed by the bench.

module tb_mul8_rr_sched;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_id;
    logic [15:0]    res_y;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   npop = 0;
    int   nacc = 0;
    logic [7:0] sa[N][16];
    logic [7:0] sb[N][16];
    int   cnt[N];
    int   nxt[N];

    mul8_rr_sched #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_y     (res_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (nxt[i] < cnt[i]) begin
                req_valid[i]    = 1'b1;
                req_a[8*i +: 8] = sa[i][nxt[i]];
                req_b[8*i +: 8] = sb[i][nxt[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input int idx, input int a, input int b);
        sa[r][idx] = 8'(a);
        sb[r][idx] = 8'(b);
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (nxt[i] < cnt[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic cycle();
        bit   xf[N];
        exp_t e;
        #1;
        chk("ready_onehot", 32'($onehot0(req_ready)), 1);
        if (res_valid && res_ready) begin
            chk("res_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_y", 32'(res_y), 32'(e.y));
                npop++;
            end
        end
        for (int i = 0; i < N; i++) begin
            xf[i] = req_valid[i] && req_ready[i];
            if (xf[i]) begin
                e.id = 2'(i);
                e.y  = 16'(req_a[8*i +: 8]) * 16'(req_b[8*i +: 8]);
                exp_q.push_back(e);
                glog.push_back(i);
                nacc++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xf[i]) nxt[i]++;
        end
        drive();
        #1;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pending()) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            nxt[i] = 0;
        end
        drive();
        exp_q.delete();
        cycle();
        cycle();
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_y", 32'(res_y), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int a0;
        rst       = 1'b1;
        res_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            nxt[i] = 0;
        end

        do_reset();

        load(1, 0, 13, 11);
        cnt[1]    = 1;
        res_ready = 1'b1;
        drive();
        #1;
        chk("sr_ready", 32'(req_ready), 32'h2);
        cycle();
        chk("sr_not_yet", 32'(res_valid), 0);
        cycle();
        chk("sr_valid", 32'(res_valid), 1);
        chk("sr_id", 32'(res_id), 1);
        chk("sr_y", 32'(res_y), 143);
        cycle();
        chk("sr_idle", 32'(res_valid), 0);
        chk("sr_req_done", 32'(req_valid), 0);

        do_reset();
        load(0, 0, 255, 255);
        load(0, 1, 0, 200);
        load(0, 2, 1, 255);
        load(0, 3, 128, 2);
        cnt[0]    = 4;
        res_ready = 1'b1;
        drive();
        p0 = npop;
        repeat (6) cycle();
        chk("ext_count", 32'(npop - p0), 4);
        chk("ext_empty", 32'(exp_q.size()), 0);

        do_reset();
        for (int i = 0; i < N; i++) begin
            load(i, 0, 10 + i, 20 + i);
            cnt[i] = 1;
        end
        res_ready = 1'b1;
        glog.delete();
        drive();
        repeat (6) cycle();
        chk("all4_ngrant", 32'(glog.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < glog.size()) chk("all4_order", 32'(glog[i]), 32'(i));
        end
        drain(20);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            load(0, k, $urandom_range(0, 255), $urandom_range(0, 255));
            load(2, k, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        cnt[0]    = 6;
        cnt[2]    = 6;
        res_ready = 1'b1;
        glog.delete();
        drive();
        drain(40);
        chk("fair_ngrant", 32'(glog.size()), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < glog.size()) chk("fair_order", 32'(glog[i]), (i % 2) ? 2 : 0);
        end

        do_reset();
        for (int k = 0; k < 5; k++) begin
            load(3, k, 50 + 17 * k, 3 + k);
        end
        cnt[3] = 5;
        drive();
        a0 = nacc;
        p0 = npop;
        repeat (2) cycle();
        chk("bp_two_acc", 32'(nacc - a0), 2);
        repeat (3) begin
            cycle();
            chk("bp_ready_low", 32'(req_ready), 0);
            chk("bp_res_valid", 32'(res_valid), 1);
            chk("bp_res_id", 32'(res_id), 3);
            if (exp_q.size() > 0) chk("bp_res_y", 32'(res_y), 32'(exp_q[0].y));
        end
        chk("bp_still_two", 32'(nacc - a0), 2);
        res_ready = 1'b1;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'h8);
        drain(30);
        chk("bp_npop", 32'(npop - p0), 5);
        chk("bp_nacc", 32'(nacc - a0), 5);

        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 3; k++) load(i, k, 7 * i + k, 9 + k);
            cnt[i] = 3;
        end
        drive();
        repeat (3) cycle();
        chk("mid_full", 32'(res_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        cycle();
        chk("mid_res_valid", 32'(res_valid), 0);
        chk("mid_res_y", 32'(res_y), 0);
        chk("mid_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) nxt[i] = 0;
        glog.delete();
        drive();
        res_ready = 1'b1;
        cycle();
        chk("mid_first_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hffff_ffff, 0);
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
